// File: rtl/lrd_pkg.sv
// rtl/lrd_pkg.sv - shared lane word type, width defaults and mode encodings
package lrd_pkg;

    localparam int LRD_DATA_W = 16;
    localparam int LRD_FRAC_W = 8;

    typedef logic signed [LRD_DATA_W-1:0] lrd_word_t;

    typedef enum logic {
        LRD_MODE_LEAKY = 1'b0,
        LRD_MODE_RELU  = 1'b1
    } lrd_mode_e;

endpackage

// File: rtl/lrd_lane.sv
// rtl/lrd_lane.sv - one lane of the leaky-ReLU derivative: leak multiply, reduce, select
// Define LRD_SAT_EN to saturate the shifted product instead of wrapping it.
import lrd_pkg::*;

module lrd_lane #(
    parameter int DATA_W = LRD_DATA_W,
    parameter int FRAC_W = LRD_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] h,
    input  lrd_mode_e         mode,
    input  logic [DATA_W-1:0] leak,
    output logic [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0] prod_full;
    logic signed [2*DATA_W-1:0] prod_shift;
    logic        [DATA_W-1:0]   prod_red;
    logic        [DATA_W-1:0]   s1_data;
    logic        [DATA_W-1:0]   s1_prod;
    logic                       s1_h_neg;
    lrd_mode_e                  s1_mode;
    logic        [DATA_W-1:0]   sel;

    assign prod_full  = $signed({{DATA_W{data[DATA_W-1]}}, data})
                      * $signed({{DATA_W{leak[DATA_W-1]}}, leak});
    // Arithmetic shift gives floor rounding for negative products
    assign prod_shift = prod_full >>> FRAC_W;

`ifdef LRD_SAT_EN
    logic pos_ovf;
    logic neg_ovf;

    assign pos_ovf = !prod_shift[2*DATA_W-1] && (|prod_shift[2*DATA_W-2:DATA_W-1]);
    assign neg_ovf =  prod_shift[2*DATA_W-1] && !(&prod_shift[2*DATA_W-2:DATA_W-1]);

    always_comb begin
        prod_red = prod_shift[DATA_W-1:0];
        if (pos_ovf) begin
            prod_red = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (neg_ovf) begin
            prod_red = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end
`else
    logic unused_prod_hi;

    assign prod_red       = prod_shift[DATA_W-1:0];
    assign unused_prod_hi = ^prod_shift[2*DATA_W-1:DATA_W];
`endif

    always_comb begin
        sel = s1_data;
        if (s1_h_neg) begin
            sel = (s1_mode == LRD_MODE_RELU) ? '0 : s1_prod;
        end
    end

    // Stage 2 loads zero for bubbles so the output bus is quiet when not valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_prod  <= '0;
            s1_h_neg <= 1'b0;
            s1_mode  <= LRD_MODE_LEAKY;
            result   <= '0;
        end else if (adv) begin
            s1_data  <= data;
            s1_prod  <= prod_red;
            s1_h_neg <= h[DATA_W-1];
            s1_mode  <= mode;
            result   <= s1_valid ? sel : '0;
        end
    end

endmodule

// File: rtl/leaky_relu_derivative_vec.sv
// rtl/leaky_relu_derivative_vec.sv - vector leaky-ReLU derivative, 2-stage pipeline with global stall
// Define LRD_SAT_EN for saturating product reduction (default wraps).
import lrd_pkg::*;

module leaky_relu_derivative_vec #(
    parameter int LANES  = 4,
    parameter int DATA_W = LRD_DATA_W,
    parameter int FRAC_W = LRD_FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lr_d_valid_in,
    output logic                    lr_d_ready_out,
    input  logic [LANES*DATA_W-1:0] lr_d_data_in,
    input  logic [LANES*DATA_W-1:0] lr_d_H_data_in,
    input  logic                    lr_mode_in,
    input  logic                    lr_leak_load,
    input  logic [DATA_W-1:0]       lr_leak_factor_in,
    output logic                    lr_d_valid_out,
    input  logic                    lr_d_ready_in,
    output logic [LANES*DATA_W-1:0] lr_d_data_out,
    output logic [15:0]             lr_d_beat_count
);

    logic              s1_valid;
    logic              s2_valid;
    logic              stall;
    logic              adv;
    logic [DATA_W-1:0] leak_q;

    assign stall          = s2_valid && !lr_d_ready_in;
    assign adv            = !stall;
    assign lr_d_ready_out = adv;
    assign lr_d_valid_out = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= lr_d_valid_in;
            s2_valid <= s1_valid;
        end
    end

    // Beats sample leak_q combinationally at acceptance, so a same-cycle load only affects later beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leak_q <= '0;
        end else if (lr_leak_load) begin
            leak_q <= lr_leak_factor_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_d_beat_count <= '0;
        end else if (s2_valid && lr_d_ready_in) begin
            lr_d_beat_count <= lr_d_beat_count + 16'd1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lrd_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv),
            .s1_valid (s1_valid),
            .data     (lr_d_data_in[i*DATA_W +: DATA_W]),
            .h        (lr_d_H_data_in[i*DATA_W +: DATA_W]),
            .mode     (lrd_mode_e'(lr_mode_in)),
            .leak     (leak_q),
            .result   (lr_d_data_out[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/leaky_relu_derivative_vec.md
LEAKY_RELU_DERIVATIVE_VEC -- requirements
Module: leaky_relu_derivative_vec

Interface
REQ-001 SHALL have parameter LANES, default 4: number of parallel lanes.
REQ-002 SHALL have parameter DATA_W, default 16: signed fixed-point word width.
REQ-003 SHALL have parameter FRAC_W, default 8: fractional bits of data and leak factor.
REQ-004 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-006 SHALL have port lr_d_valid_in  in  1: input beat valid.
REQ-007 SHALL have port lr_d_ready_out  out  1: block can accept an input beat.
REQ-008 SHALL have port lr_d_data_in  in  LANES*DATA_W: upstream gradients, lane i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port lr_d_H_data_in  in  LANES*DATA_W: forward pre-activations, same packing.
REQ-010 SHALL have port lr_mode_in  in  1: 0 = leaky derivative, 1 = plain ReLU derivative; sampled per beat.
REQ-011 SHALL have port lr_leak_load  in  1: strobe that loads the leak factor register.
REQ-012 SHALL have port lr_leak_factor_in  in  DATA_W: signed leak factor, same Q format as the data.
REQ-013 SHALL have port lr_d_valid_out  out  1: output beat valid.
REQ-014 SHALL have port lr_d_ready_in  in  1: downstream accepts the output beat.
REQ-015 SHALL have port lr_d_data_out  out  LANES*DATA_W: derivative results, same packing.
REQ-016 SHALL have port lr_d_beat_count  out  16: count of completed output transfers.

Function
REQ-017 SHALL accept an input beat when lr_d_valid_in and lr_d_ready_out are both high; output transfer occurs when lr_d_valid_out and lr_d_ready_in are both high.
REQ-018 SHALL implement a 2-stage pipeline: stage 1 registers data, H sign, mode and the product; stage 2 registers the selected result; latency is exactly 2 cycles with no stall.
REQ-019 SHALL stall globally when lr_d_valid_out is high and lr_d_ready_in is low; lr_d_ready_out = NOT stall; all stage registers hold during a stall.
REQ-020 SHALL sustain one beat per cycle with lr_d_ready_in held high; no beat lost or duplicated under arbitrary backpressure.
REQ-021 SHALL, per lane, output data when H >= 0 (zero counts as non-negative); when H < 0, output 0 in mode 1, else the leak product.
REQ-022 SHALL form the product as full 2*DATA_W signed data*leak, arithmetic-shifted right by FRAC_W (round toward negative infinity), reduced to DATA_W per REQ-029.
REQ-023 SHALL use the leak register value current at input acceptance; a load in the same cycle as acceptance applies only to later beats.
REQ-024 SHALL keep lr_d_data_out at 0 whenever lr_d_valid_out is low.
REQ-025 SHALL increment lr_d_beat_count by 1 per output transfer, wrapping 0xFFFF -> 0x0000.
REQ-026 SHALL allow lr_leak_load at any time, including during a stall, without affecting beats already accepted.

Reset
REQ-027 SHALL, on rst, clear both stage valids, lr_d_valid_out=0, lr_d_data_out=0, lr_d_beat_count=0, leak register=0; lr_d_ready_out=1 while rst is high and after release.
REQ-028 SHALL discard all in-flight beats when rst asserts mid-operation; no output follows release until a new beat is accepted.

Configuration
REQ-029 SHALL, with LRD_SAT_EN defined, saturate the shifted product to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; without it, take the low DATA_W bits (two's-complement wrap).

Structure
REQ-030 SHALL place the lane word typedef, DATA_W/FRAC_W defaults and mode encodings in a shared package lrd_pkg.
REQ-031 SHALL implement the per-lane multiply/select datapath as sub-module lrd_lane, instantiated LANES times; control and the counter remain in the top.

Verification
REQ-032 SHALL verify: leak 0x0080, mode 0, data 0x0200, H 0xFF00 -> 0x0100 two cycles after acceptance; H 0x0000 -> 0x0200.
REQ-033 SHALL verify: mode 1, data 0x0200, H 0x8000 -> 0x0000; H 0x0001 -> 0x0200.
REQ-034 SHALL verify: leak 0x0200, data 0x7FFF, H negative -> 0x7FFF with LRD_SAT_EN, 0xFFFE without.
REQ-035 SHALL verify: 8 back-to-back beats with lr_d_ready_in toggling 1,0,0,1 -> all 8 results in order, lr_d_beat_count=8.
REQ-036 SHALL verify: leak load 0x0080 in the cycle beat A is accepted, beat B next cycle, prior leak 0x0040, data 0x0400, H negative -> A=0x0100, B=0x0200.
REQ-037 SHALL verify: rst asserted with 2 beats in flight -> lr_d_valid_out=0, data 0, count 0, no output after release.
